pixel_word_fifo: RTL

- Buffers the 8-bit pixel stream from the ADC controller and packs it into 32-bit words for the imager APB read path.
- Sits between the ADC serial capture stage and the APB interface, one instance per camera.
- Provides empty, almost-full, full and sticky overflow status, plus a word count.
- Supports end-of-frame flushing of a partial word.

---
 rtl/pixel_word_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pixel_word_fifo.sv
// pixel_word_fifo: packs 8-bit pixel bytes into 32-bit words and buffers
// them for the APB read path. Status flags and the read port are registered.
// A frame_end flushes a partial word out, zero-padded in the higher lanes.
module pixel_word_fifo #(
    parameter int DEPTH_WORDS  = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int AFULL_THRESH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  frame_end,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  afull,
    output logic                  full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int CW = ADDR_WIDTH + 1;

    // Word storage: simple dual-port, written by the packer, read into rd_data_q
    logic [31:0]           ram_q [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           pack_q, pack_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;

    logic                  is_full, is_empty;
    logic [31:0]           pack_byte;
    logic                  push_req, push_acc, pop_acc, ovf_set, ram_we;
    logic [31:0]           push_word;

    // Packer, push/pop arbitration and next-state for all registers
    always_comb begin
        is_full    = (count_q == CW'(DEPTH_WORDS));
        is_empty   = (count_q == '0);

        // Current packer with the incoming byte dropped into its lane; lanes
        // above it are still zero because the packer is cleared on every push.
        pack_byte  = pack_q;
        pack_byte[{lane_q, 3'b000} +: 8] = wr_data;

        lane_d     = lane_q;
        pack_d     = pack_q;
        push_req   = 1'b0;
        push_word  = pack_q;
        ovf_set    = 1'b0;

        if (wr_en) begin
            if (is_full) begin
                // Byte is lost; the partial word stays as it was.
                ovf_set = 1'b1;
            end else if (lane_q == 2'd3 || frame_end) begin
                push_req  = 1'b1;
                push_word = pack_byte;
                lane_d    = 2'd0;
                pack_d    = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                pack_d = pack_byte;
            end
        end else if (frame_end && lane_q != 2'd0) begin
            // Pad push of a partial word; if there is no room it is discarded.
            push_req  = 1'b1;
            push_word = pack_q;
            lane_d    = 2'd0;
            pack_d    = '0;
            ovf_set   = is_full;
        end

        // Fullness is judged at the start of the cycle, so a same-cycle pop
        // never makes room for a push.
        push_acc   = push_req && !is_full;
        pop_acc    = rd_en && !is_empty;

        wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push_acc);
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(pop_acc);
        count_d    = count_q + CW'(push_acc) - CW'(pop_acc);

        rd_data_d  = pop_acc ? ram_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = pop_acc;
        overflow_d = overflow_q | ovf_set;
        ram_we     = push_acc;

        // flush wins over every other request; rd_data is left untouched.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            lane_d     = 2'd0;
            pack_d     = '0;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
            overflow_d = 1'b0;
            ram_we     = 1'b0;
        end

        // Flags follow the updated count so they track this edge's push/pop.
        empty_d    = (count_d == '0);
        afull_d    = (count_d >= CW'(AFULL_THRESH));
        full_d     = (count_d == CW'(DEPTH_WORDS));
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_q     <= 2'd0;
            pack_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM write port; contents need no reset since pointers gate all reads
    always_ff @(posedge clk) begin
        if (reset && ram_we) begin
            ram_q[wr_ptr_q] <= push_word;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign empty      = empty_q;
    assign afull      = afull_q;
    assign full       = full_q;
    assign overflow   = overflow_q;
    assign word_count = count_q;

endmodule
